// File: rtl/parser_rr_scheduler.sv
// Round-robin share of one header parser among N_PORTS ingress buffers, one packet in flight.
// Grant appears one clk after an eligible request; parser hdr_ready backpressure holds the grant.
module parser_rr_scheduler #(
  parameter int N_PORTS      = 4,
  parameter int PORT_W       = 2,
  parameter int HEADER_BYTES = 192,
  parameter int TIMEOUT_CYC  = 64,
  parameter int CNT_W        = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_PORTS-1:0]                port_en,
  input  logic [N_PORTS-1:0]                req_valid,
  input  logic [N_PORTS*8*HEADER_BYTES-1:0] req_hdr_flat,
  output logic [N_PORTS-1:0]                req_ready,
  output logic                              prs_hdr_valid,
  output logic [8*HEADER_BYTES-1:0]         prs_hdr_flat,
  input  logic                              prs_hdr_ready,
  input  logic                              prs_res_valid,
  input  logic                              prs_res_ready,
  output logic [PORT_W-1:0]                 res_port_id,
  output logic                              res_tag_valid,
  output logic                              timeout_err,
  output logic [N_PORTS*CNT_W-1:0]          acc_cnt_flat
);

  localparam int HDR_W = 8 * HEADER_BYTES;
  localparam int WD_W  = 16;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]         state;
  logic [PORT_W-1:0]  rr_ptr;
  logic [PORT_W-1:0]  grant;
  logic [PORT_W-1:0]  grant_next_ptr;
  logic [PORT_W-1:0]  pick;
  logic               pick_found;
  logic [WD_W-1:0]    wd_cnt;
  logic [CNT_W-1:0]   acc_cnt [N_PORTS];
  logic [N_PORTS-1:0] eligible;
  logic [HDR_W-1:0]   hdr_sel;
  logic               in_offer;
  logic               accept;
  logic               complete;
  logic               expire;

  assign eligible = req_valid & port_en;
  assign in_offer = (state == S_OFFER);
  assign accept   = in_offer && prs_hdr_ready;
  assign complete = prs_res_valid && prs_res_ready;
  assign expire   = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // First eligible port starting at rr_ptr, wrapping modulo N_PORTS.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (!pick_found && eligible[p] && ((int'(rr_ptr) + i) % N_PORTS == p)) begin
          pick_found = 1'b1;
          pick       = PORT_W'(p);
        end
      end
    end
  end

  assign grant_next_ptr = (grant == PORT_W'(N_PORTS - 1)) ? '0 : grant + PORT_W'(1);

  always_comb begin
    hdr_sel = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (grant == PORT_W'(p)) hdr_sel = req_hdr_flat[p*HDR_W +: HDR_W];
    end
  end

  always_comb begin
    req_ready = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      req_ready[p] = in_offer && (grant == PORT_W'(p)) && prs_hdr_ready;
    end
  end

  assign prs_hdr_valid = in_offer;
  assign prs_hdr_flat  = in_offer ? hdr_sel : '0;
  assign res_tag_valid = (state == S_BUSY);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      res_port_id <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      for (int p = 0; p < N_PORTS; p++) acc_cnt[p] <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant <= pick;
            state <= S_OFFER;
          end
        end
        S_OFFER: begin
          // Grant is held even if the requester drops valid or gets masked.
          if (prs_hdr_ready) begin
            rr_ptr      <= grant_next_ptr;
            res_port_id <= grant;
            wd_cnt      <= '0;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          wd_cnt <= wd_cnt + WD_W'(1);
          if (complete) begin
            state <= S_IDLE;
          end else if (expire) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      for (int p = 0; p < N_PORTS; p++) begin
        if (accept && (grant == PORT_W'(p))) acc_cnt[p] <= acc_cnt[p] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_acc_flat
    assign acc_cnt_flat[g*CNT_W +: CNT_W] = acc_cnt[g];
  end

endmodule
